// File: rtl/apb4_master_if.sv
// apb4_master_if: request/response and APB4 bus signals of apb4_master
interface apb4_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_write;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [3:0]            req_strb;
   logic [2:0]            req_prot;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  rsp_timeout;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [2:0]            pprot;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [3:0]            pstrb;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;
   modport master (
      input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot, rsp_ready,
             prdata, pready, pslverr,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             paddr, pprot, psel, penable, pwrite, pwdata, pstrb
   );
   modport slave (
      output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot, rsp_ready,
             prdata, pready, pslverr,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             paddr, pprot, psel, penable, pwrite, pwdata, pstrb
   );
endinterface

// File: rtl/apb4_master.sv
// apb4_master: valid/ready to APB4 initiator; define APB4_MASTER_TIMEOUT_EN for bounded ACCESS wait with abort
module apb4_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic           pclk,
   input logic           preset,
   apb4_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            strb_q, strb_d;
   logic [2:0]            prot_q, prot_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  timeout;
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end
`ifdef APB4_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;
   // pready in the last counted cycle still completes normally
   assign timeout = state_q == ACCESS && !bus.pready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef APB4_MASTER_TIMEOUT_EN
         cnt_q   <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         prot_q  <= prot_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef APB4_MASTER_TIMEOUT_EN
         cnt_q   <= cnt_d;
         to_q    <= to_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      prot_d  = prot_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef APB4_MASTER_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = to_q;
`endif
      case (state_q)
         IDLE: if (bus.req_valid) begin
            state_d = SETUP;
            addr_d  = bus.req_addr;
            write_d = bus.req_write;
            // reads present zero data and strobes on the bus
            wdata_d = bus.req_write ? bus.req_wdata : '0;
            strb_d  = bus.req_write ? bus.req_strb : '0;
            prot_d  = bus.req_prot;
         end
         SETUP: begin
            state_d = ACCESS;
`ifdef APB4_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ACCESS: begin
`ifdef APB4_MASTER_TIMEOUT_EN
            cnt_d = bus.pready ? cnt_q : cnt_q + 1'b1;
            to_d  = timeout;
`endif
            if (bus.pready || timeout) begin
               state_d = RESP;
               rdata_d = (bus.pready && !write_q) ? bus.prdata : '0;
               err_d   = bus.pready ? bus.pslverr : 1'b1;
            end
         end
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = !preset && state_q == IDLE;
      bus.psel      = !preset && (state_q == SETUP || state_q == ACCESS);
      bus.penable   = !preset && state_q == ACCESS;
      bus.rsp_valid = !preset && state_q == RESP;
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
`ifdef APB4_MASTER_TIMEOUT_EN
      bus.rsp_timeout = to_q;
`else
      bus.rsp_timeout = 1'b0;
`endif
      bus.paddr  = addr_q;
      bus.pwrite = write_q;
      bus.pwdata = wdata_q;
      bus.pstrb  = strb_q;
      bus.pprot  = prot_q;
   end
endmodule

// File: tb/tb_apb4_master.sv
// tb_apb4_master: random and directed transfers against a memory-backed transaction model
module tb_apb4_master;
   localparam int TO = 4;
`ifdef APB4_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic        pclk = 1'b0;
   logic        preset = 1'b1;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];

   apb4_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .preset(preset), .bus(bus)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ctl();
      return {bus.psel, bus.penable, bus.req_ready, bus.rsp_valid};
   endfunction

   function automatic logic [71:0] apb();
      return {bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot};
   endfunction

   // One complete transfer: the slave inserts `waits` wait states, then answers with `err`;
   // the requester holds off rsp_ready for `bp` cycles.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [2:0] prot, input int waits,
                       input logic err, input int bp);
      logic        tmo;
      int          acc;
      logic [31:0] exp_wd, exp_rd;
      logic [3:0]  exp_st, idx;
      tmo    = TO_EN && waits >= TO;
      acc    = tmo ? TO : waits + 1;
      idx    = addr[5:2];
      exp_wd = wr ? wd : 32'h0;
      exp_st = wr ? strb : 4'h0;
      exp_rd = (wr || tmo) ? 32'h0 : ref_mem[idx];
      if (wr && !err && !tmo)
         for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      chk("idle_ctl", 128'(ctl()), 128'(4'b0010));
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_write = wr;
      bus.req_wdata = wd;
      bus.req_strb  = strb;
      bus.req_prot  = prot;
      @(negedge pclk);
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_write = 1'($urandom);
      chk("setup_ctl", 128'(ctl()), 128'(4'b1000));
      chk("setup_apb", 128'(apb()), 128'({addr, wr, exp_wd, exp_st, prot}));
      for (int i = 0; i < acc; i++) begin
         @(negedge pclk);
         chk("access_ctl", 128'(ctl()), 128'(4'b1100));
         chk("access_apb", 128'(apb()), 128'({addr, wr, exp_wd, exp_st, prot}));
         if (i == waits) begin
            bus.pready  = 1'b1;
            bus.pslverr = err;
            bus.prdata  = slv_mem[bus.paddr[5:2]];
            if (bus.pwrite && !err)
               for (int b = 0; b < 4; b++)
                  if (bus.pstrb[b]) slv_mem[bus.paddr[5:2]][8*b +: 8] = bus.pwdata[8*b +: 8];
         end else begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b1;
            bus.prdata  = $urandom;
         end
      end
      @(negedge pclk);
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = $urandom;
      for (int i = 0; i <= bp; i++) begin
         chk("resp_ctl", 128'(ctl()), 128'(4'b0001));
         chk("resp_data", 128'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}),
             128'({exp_rd, err || tmo, tmo}));
         bus.rsp_ready = (i == bp);
         @(negedge pclk);
      end
      bus.rsp_ready = 1'b0;
      chk("post_ctl", 128'(ctl()), 128'(4'b0010));
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_write = 1'b0;
      bus.req_wdata = '0;
      bus.req_strb  = '0;
      bus.req_prot  = '0;
      bus.rsp_ready = 1'b0;
      bus.prdata    = '0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 32'h0;
         slv_mem[i] = 32'h0;
      end
      repeat (3) @(negedge pclk);
      chk("reset_ctl", 128'(ctl()), 128'(4'b0000));
      chk("reset_rsp", 128'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}), 128'(0));
      chk("reset_apb", 128'(apb()), 128'(0));
      preset = 1'b0;
      @(negedge pclk);
      ref_mem[1] = 32'hDEAD_BEEF;
      slv_mem[1] = 32'hDEAD_BEEF;
      xfer(32'h1000_0004, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b0, 0);
      xfer(32'h0000_0008, 1'b1, 32'h0000_00FF, 4'hF, 3'd2, 3, 1'b0, 0);
      xfer(32'h0000_0008, 1'b0, 32'h1234_5678, 4'hF, 3'd1, 1, 1'b0, 0);
      xfer(32'h0000_0020, 1'b1, 32'hCAFE_F00D, 4'h5, 3'd7, 2, 1'b1, 0);
      xfer(32'h0000_0024, 1'b0, 32'h0, 4'h0, 3'd0, 2, 1'b0, 0);
      xfer(32'h0000_0030, 1'b1, 32'hA5A5_5A5A, 4'h3, 3'd4, 1, 1'b0, 5);
      xfer(32'h0000_0014, 1'b0, 32'h0, 4'h0, 3'd0, 300, 1'b0, 0);
      for (int n = 0; n < 40; n++)
         xfer($urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
              $urandom_range(0, 6), $urandom_range(0, 4) == 0, $urandom_range(0, 2));
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0010;
      bus.req_write = 1'b0;
      @(negedge pclk);
      bus.req_valid = 1'b0;
      @(negedge pclk);
      chk("rst_access_ctl", 128'(ctl()), 128'(4'b1100));
      preset = 1'b1;
      @(negedge pclk);
      chk("rst_ctl", 128'(ctl()), 128'(4'b0000));
      preset = 1'b0;
      @(negedge pclk);
      chk("rst_idle_ctl", 128'(ctl()), 128'(4'b0010));
      xfer(32'h0000_0008, 1'b0, 32'h0, 4'h0, 3'd3, 1, 1'b0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
